cva6_cfg_info_responder: RTL



---
 rtl/cva6_cfg_info_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cva6_cfg_info_responder.sv
// rtl/cva6_cfg_info_responder.sv - read-only CVA6 configuration table with word-read and stream-dump ports
package config_pkg;

  typedef enum logic [1:0] {
    WB       = 2'd0,
    WT       = 2'd1,
    HPDCACHE = 2'd2
  } cache_type_t;

  // Only the fields this responder publishes; mirrors the names used by the core configuration.
  typedef struct packed {
    int unsigned XLEN;
    bit          RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU, RVV;
    int unsigned IcacheByteSize;
    int unsigned DcacheByteSize;
    int unsigned IcacheSetAssoc;
    int unsigned DcacheSetAssoc;
    int unsigned NrPMPEntries;
    int unsigned NrScoreboardEntries;
    bit          MmuPresent, DebugEn, PerfCounterEn, CvxifEn, FpgaEn;
    cache_type_t DCacheType;
    logic [63:0] HaltAddress;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN: 32'd0,
    RVA: 1'b0, RVB: 1'b0, RVC: 1'b0, RVD: 1'b0, RVF: 1'b0,
    RVH: 1'b0, RVS: 1'b0, RVU: 1'b0, RVV: 1'b0,
    IcacheByteSize: 32'd0,
    DcacheByteSize: 32'd0,
    IcacheSetAssoc: 32'd0,
    DcacheSetAssoc: 32'd0,
    NrPMPEntries: 32'd0,
    NrScoreboardEntries: 32'd0,
    MmuPresent: 1'b0, DebugEn: 1'b0, PerfCounterEn: 1'b0, CvxifEn: 1'b0, FpgaEn: 1'b0,
    DCacheType: WB,
    HaltAddress: 64'h0
  };

endpackage

module cva6_cfg_info_responder #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
  parameter int unsigned           AddrWidth = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 rerr_o,
  input  logic                 rready_i,
  input  logic                 dump_start_i,
  output logic                 s_valid_o,
  output logic [31:0]          s_data_o,
  output logic                 s_last_o,
  input  logic                 s_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [31:0] Magic = 32'h4356_4136;

  function automatic logic [31:0] cfg_word(input logic [2:0] i);
    logic [31:0] w;
    w = '0;
    case (i)
      3'd0: w = Magic;
      3'd1: w = CVA6Cfg.XLEN;
      3'd2: begin
        w[0]  = CVA6Cfg.RVA;
        w[1]  = CVA6Cfg.RVB;
        w[2]  = CVA6Cfg.RVC;
        w[3]  = CVA6Cfg.RVD;
        w[5]  = CVA6Cfg.RVF;
        w[7]  = CVA6Cfg.RVH;
        w[8]  = 1'b1;
        w[12] = 1'b1;
        w[18] = CVA6Cfg.RVS;
        w[20] = CVA6Cfg.RVU;
        w[21] = CVA6Cfg.RVV;
      end
      3'd3: w = CVA6Cfg.IcacheByteSize;
      3'd4: w = CVA6Cfg.DcacheByteSize;
      3'd5: w = {CVA6Cfg.IcacheSetAssoc[7:0], CVA6Cfg.DcacheSetAssoc[7:0],
                 CVA6Cfg.NrPMPEntries[7:0], CVA6Cfg.NrScoreboardEntries[7:0]};
      3'd6: begin
        w[0]   = CVA6Cfg.MmuPresent;
        w[1]   = CVA6Cfg.DebugEn;
        w[2]   = CVA6Cfg.PerfCounterEn;
        w[3]   = CVA6Cfg.CvxifEn;
        w[4]   = CVA6Cfg.FpgaEn;
        w[9:8] = CVA6Cfg.DCacheType;
      end
      default: w = CVA6Cfg.HaltAddress[31:0];
    endcase
    return w;
  endfunction

  // Zero-extended index keeps the range check independent of AddrWidth.
  logic [31:0] addr_ext;
  logic        addr_oor;
  assign addr_ext = 32'(addr_i);
  assign addr_oor = (addr_ext >= 32'd8);

  assign gnt_o = req_i & (~rvalid_o | rready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'h0;
      rerr_o   <= 1'b0;
    end else if (gnt_o) begin
      rvalid_o <= 1'b1;
      rdata_o  <= addr_oor ? 32'h0 : cfg_word(addr_ext[2:0]);
      rerr_o   <= addr_oor;
    end else if (rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

  typedef enum logic {IDLE, DUMP} state_t;
  state_t     state;
  logic [2:0] idx;

  // s_valid_o is always high in DUMP, so s_ready_i alone marks a handshake there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= 3'd0;
      s_valid_o <= 1'b0;
      s_data_o  <= 32'h0;
      s_last_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start_i && !done_o) begin
            state     <= DUMP;
            idx       <= 3'd0;
            s_valid_o <= 1'b1;
            s_data_o  <= cfg_word(3'd0);
            s_last_o  <= 1'b0;
            busy_o    <= 1'b1;
          end
        end
        DUMP: begin
          if (s_ready_i) begin
            if (idx == 3'd7) begin
              state     <= IDLE;
              idx       <= 3'd0;
              s_valid_o <= 1'b0;
              s_data_o  <= 32'h0;
              s_last_o  <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              idx      <= idx + 3'd1;
              s_data_o <= cfg_word(idx + 3'd1);
              s_last_o <= (idx == 3'd6);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
